// File: rtl/square_wave_period_detector.sv
// Square-wave period detector: thresholds an unsigned 16-bit audio stream with
// hysteresis, then times rising-to-rising (period) and rising-to-falling
// (high time) distances in clk cycles. It flags lock when consecutive periods
// agree within TOLERANCE and pulses timeout when no rising edge arrives for
// MAX_PERIOD cycles.
module square_wave_period_detector #(
  parameter int unsigned CLOCK_RATE  = 50000000,
  parameter logic [15:0] THRESH_HIGH = 16'hC000,
  parameter logic [15:0] THRESH_LOW  = 16'h4000,
  parameter int unsigned MAX_PERIOD  = CLOCK_RATE,
  parameter int unsigned TOLERANCE   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        audio_clk_en,
  input  logic [15:0] in,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        valid,
  output logic        locked,
  output logic        timeout
);

  localparam logic [31:0] LP_MAX = 32'(MAX_PERIOD);
  localparam logic [32:0] LP_TOL = 33'(TOLERANCE);

  typedef enum logic [1:0] {
    StSeek,
    StMeasure,
    StTrack
  } state_t;

  // Level tracking
  logic        r_lvl;
  logic        r_lvl_d;
  logic        w_lvl_next;
  logic        w_rise;
  logic        w_fall;

  // Cycle counters
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_next;
  logic [31:0] r_hi_cnt;
  logic [31:0] w_hi_cnt_next;
  logic        w_cnt_sat;

  // Lock comparison
  logic [31:0] r_prev;
  logic [31:0] w_prev_next;
  logic [32:0] w_diff;

  // FSM and registered outputs
  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_period;
  logic [31:0] w_period_next;
  logic [31:0] r_high_time;
  logic [31:0] w_high_time_next;
  logic        r_valid;
  logic        w_valid_next;
  logic        r_locked;
  logic        w_locked_next;
  logic        r_timeout;
  logic        w_timeout_next;

  // Hysteresis slicer: only strobed samples can move the level, and values in
  // the dead band between the thresholds leave it unchanged.
  always_comb begin
    w_lvl_next = r_lvl;
    if (audio_clk_en) begin
      if (in >= THRESH_HIGH) begin
        w_lvl_next = 1'b1;
      end else if (in <= THRESH_LOW) begin
        w_lvl_next = 1'b0;
      end
    end
  end

  assign w_rise = r_lvl & ~r_lvl_d;
  assign w_fall = ~r_lvl & r_lvl_d;

  // Level register and its one-cycle delay used for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
    end else begin
      r_lvl   <= w_lvl_next;
      r_lvl_d <= r_lvl;
    end
  end

  assign w_cnt_sat = (r_cnt >= LP_MAX);

  // Cycle counter restarts at 1 on a rise so that it reads the full distance
  // at the next edge; it parks at MAX_PERIOD while the signal is absent.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_rise) begin
      w_cnt_next = 32'd1;
    end else if (!w_cnt_sat) begin
      w_cnt_next = r_cnt + 32'd1;
    end
  end

  // High time is the count at the falling edge; held if no fall occurs.
  always_comb begin
    w_hi_cnt_next = r_hi_cnt;
    if (w_fall) begin
      w_hi_cnt_next = r_cnt;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt    <= 32'd0;
      r_hi_cnt <= 32'd0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_hi_cnt <= w_hi_cnt_next;
    end
  end

  // Absolute period difference, widened by one bit so it can never wrap.
  always_comb begin
    if (r_cnt >= r_prev) begin
      w_diff = {1'b0, r_cnt} - {1'b0, r_prev};
    end else begin
      w_diff = {1'b0, r_prev} - {1'b0, r_cnt};
    end
  end

  // Next-state and output logic; a rise takes priority over a saturated count
  // so a period of exactly MAX_PERIOD is still reported as a measurement.
  always_comb begin
    w_state_next     = r_state;
    w_period_next    = r_period;
    w_high_time_next = r_high_time;
    w_valid_next     = 1'b0;
    w_locked_next    = r_locked;
    w_timeout_next   = 1'b0;
    w_prev_next      = r_prev;
    case (r_state)
      StSeek: begin
        if (w_rise) begin
          w_state_next = StMeasure;
        end
      end
      StMeasure: begin
        if (w_rise) begin
          w_period_next    = r_cnt;
          w_high_time_next = r_hi_cnt;
          w_valid_next     = 1'b1;
          w_prev_next      = r_cnt;
          w_locked_next    = 1'b0;
          w_state_next     = StTrack;
        end else if (w_cnt_sat) begin
          w_timeout_next   = 1'b1;
          w_period_next    = 32'd0;
          w_high_time_next = 32'd0;
          w_locked_next    = 1'b0;
          w_state_next     = StSeek;
        end
      end
      StTrack: begin
        if (w_rise) begin
          w_period_next    = r_cnt;
          w_high_time_next = r_hi_cnt;
          w_valid_next     = 1'b1;
          w_prev_next      = r_cnt;
          w_locked_next    = (w_diff <= LP_TOL);
        end else if (w_cnt_sat) begin
          w_timeout_next   = 1'b1;
          w_period_next    = 32'd0;
          w_high_time_next = 32'd0;
          w_locked_next    = 1'b0;
          w_state_next     = StSeek;
        end
      end
      default: begin
        w_state_next = StSeek;
      end
    endcase
  end

  // State and output registers; reset discards any partial measurement.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StSeek;
      r_period    <= 32'd0;
      r_high_time <= 32'd0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_timeout   <= 1'b0;
      r_prev      <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_period    <= w_period_next;
      r_high_time <= w_high_time_next;
      r_valid     <= w_valid_next;
      r_locked    <= w_locked_next;
      r_timeout   <= w_timeout_next;
      r_prev      <= w_prev_next;
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign locked    = r_locked;
  assign timeout   = r_timeout;

endmodule
